// File: rtl/cp0_tlb_regs_if.sv
// Signal bundle between the WB stage / TLB and the CP0 TLB register file.
interface cp0_tlb_regs_if #(
   parameter int unsigned TLBNUM = 16
);
   localparam int unsigned IDX_W = $clog2(TLBNUM);

   logic             wb_ex;
   logic             wb_bd;
   logic             wb_eret;
   logic [4:0]       wb_excode;
   logic [31:0]      wb_pc;
   logic [31:0]      wb_badvaddr;
   logic [5:0]       ext_int_in;
   logic [7:0]       cp0_addr;
   logic [31:0]      cp0_rdata;
   logic             mtc0_we;
   logic [31:0]      cp0_wdata;
   logic             tlbp;
   logic             tlbr;
   logic             tlbwi;
   logic             tlbwr;
   logic             s1_found;
   logic [IDX_W-1:0] s1_index;
   logic [18:0]      r_vpn2;
   logic [7:0]       r_asid;
   logic             r_g;
   logic [19:0]      r_pfn0;
   logic [19:0]      r_pfn1;
   logic [2:0]       r_c0;
   logic [2:0]       r_c1;
   logic             r_d0;
   logic             r_d1;
   logic             r_v0;
   logic             r_v1;
   logic [IDX_W-1:0] tlb_w_index;
   logic [31:0]      cp0_status;
   logic [31:0]      cp0_cause;
   logic [31:0]      cp0_epc;
   logic [31:0]      cp0_entryhi;
   logic [31:0]      cp0_entrylo0;
   logic [31:0]      cp0_entrylo1;
   logic [31:0]      cp0_index;
   logic             int_req;

   modport master (
      output wb_ex, wb_bd, wb_eret, wb_excode, wb_pc, wb_badvaddr, ext_int_in,
             cp0_addr, mtc0_we, cp0_wdata, tlbp, tlbr, tlbwi, tlbwr,
             s1_found, s1_index, r_vpn2, r_asid, r_g, r_pfn0, r_pfn1,
             r_c0, r_c1, r_d0, r_d1, r_v0, r_v1,
      input  cp0_rdata, tlb_w_index, cp0_status, cp0_cause, cp0_epc,
             cp0_entryhi, cp0_entrylo0, cp0_entrylo1, cp0_index, int_req
   );

   modport slave (
      input  wb_ex, wb_bd, wb_eret, wb_excode, wb_pc, wb_badvaddr, ext_int_in,
             cp0_addr, mtc0_we, cp0_wdata, tlbp, tlbr, tlbwi, tlbwr,
             s1_found, s1_index, r_vpn2, r_asid, r_g, r_pfn0, r_pfn1,
             r_c0, r_c1, r_d0, r_d1, r_v0, r_v1,
      output cp0_rdata, tlb_w_index, cp0_status, cp0_cause, cp0_epc,
             cp0_entryhi, cp0_entrylo0, cp0_entrylo1, cp0_index, int_req
   );
endinterface

// File: rtl/cp0_tlb_regs.sv
// CP0 register file with TLB support registers (Index/Random/Wired/Context/EntryHi/Lo),
// prescaled Count/Compare timer and a registered interrupt request.
module cp0_tlb_regs #(
   parameter int unsigned TLBNUM    = 16,
   parameter int unsigned COUNT_DIV = 2
) (
   input logic           clk,
   input logic           resetn,
   cp0_tlb_regs_if.slave bus
);
   localparam int unsigned IDX_W = $clog2(TLBNUM);
   localparam int unsigned PRE_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
   localparam logic [IDX_W-1:0] RND_TOP = IDX_W'(TLBNUM - 1);
   localparam logic [PRE_W-1:0] PRE_TOP = PRE_W'(COUNT_DIV - 1);

   localparam logic [7:0] A_INDEX    = 8'd0;
   localparam logic [7:0] A_RANDOM   = 8'd8;
   localparam logic [7:0] A_ENTRYLO0 = 8'd16;
   localparam logic [7:0] A_ENTRYLO1 = 8'd24;
   localparam logic [7:0] A_CONTEXT  = 8'd32;
   localparam logic [7:0] A_WIRED    = 8'd48;
   localparam logic [7:0] A_BADVADDR = 8'd64;
   localparam logic [7:0] A_COUNT    = 8'd72;
   localparam logic [7:0] A_ENTRYHI  = 8'd80;
   localparam logic [7:0] A_COMPARE  = 8'd88;
   localparam logic [7:0] A_STATUS   = 8'd96;
   localparam logic [7:0] A_CAUSE    = 8'd104;
   localparam logic [7:0] A_EPC      = 8'd112;

   logic [7:0]       status_im;
   logic             status_exl;
   logic             status_ie;
   logic             cause_bd;
   logic             cause_ti;
   logic [7:0]       cause_ip;
   logic [4:0]       cause_excode;
   logic [31:0]      epc;
   logic [31:0]      badvaddr;
   logic [31:0]      count;
   logic [31:0]      compare;
   logic [PRE_W-1:0] prescale;
   logic             index_p;
   logic [IDX_W-1:0] index_val;
   logic [IDX_W-1:0] random_val;
   logic [IDX_W-1:0] wired_val;
   logic [18:0]      entryhi_vpn2;
   logic [7:0]       entryhi_asid;
   logic [25:0]      entrylo0;
   logic [25:0]      entrylo1;
   logic [8:0]       context_ptebase;
   logic [18:0]      context_badvpn2;
   logic             int_req_q;

   logic wr_index, wr_entrylo0, wr_entrylo1, wr_context, wr_wired, wr_count;
   logic wr_entryhi, wr_compare, wr_status, wr_cause, wr_epc;
   logic tlb_exc, bva_exc, epc_load;

   assign wr_index    = bus.mtc0_we && (bus.cp0_addr == A_INDEX);
   assign wr_entrylo0 = bus.mtc0_we && (bus.cp0_addr == A_ENTRYLO0);
   assign wr_entrylo1 = bus.mtc0_we && (bus.cp0_addr == A_ENTRYLO1);
   assign wr_context  = bus.mtc0_we && (bus.cp0_addr == A_CONTEXT);
   assign wr_wired    = bus.mtc0_we && (bus.cp0_addr == A_WIRED);
   assign wr_count    = bus.mtc0_we && (bus.cp0_addr == A_COUNT);
   assign wr_entryhi  = bus.mtc0_we && (bus.cp0_addr == A_ENTRYHI);
   assign wr_compare  = bus.mtc0_we && (bus.cp0_addr == A_COMPARE);
   assign wr_status   = bus.mtc0_we && (bus.cp0_addr == A_STATUS);
   assign wr_cause    = bus.mtc0_we && (bus.cp0_addr == A_CAUSE);
   assign wr_epc      = bus.mtc0_we && (bus.cp0_addr == A_EPC);

   // TLB refill/invalid/modified exceptions (1..3) also capture the faulting VPN2
   assign bva_exc  = bus.wb_ex && (bus.wb_excode >= 5'd1) && (bus.wb_excode <= 5'd5);
   assign tlb_exc  = bus.wb_ex && (bus.wb_excode >= 5'd1) && (bus.wb_excode <= 5'd3);
   assign epc_load = bus.wb_ex && !status_exl;

   // Exception state: Status, Cause (except TI), EPC, BadVAddr
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         status_im    <= '0;
         status_exl   <= 1'b0;
         status_ie    <= 1'b0;
         cause_bd     <= 1'b0;
         cause_ip     <= '0;
         cause_excode <= '0;
         epc          <= '0;
         badvaddr     <= '0;
      end else begin
         if (wr_status) begin
            status_im <= bus.cp0_wdata[15:8];
            status_ie <= bus.cp0_wdata[0];
         end
         if (bus.wb_ex)        status_exl <= 1'b1;
         else if (bus.wb_eret) status_exl <= 1'b0;
         else if (wr_status)   status_exl <= bus.cp0_wdata[1];
         cause_ip <= {bus.ext_int_in[5] | cause_ti, bus.ext_int_in[4:0],
                      wr_cause ? bus.cp0_wdata[9:8] : cause_ip[1:0]};
         if (bus.wb_ex) begin
            cause_excode <= bus.wb_excode;
            if (!status_exl) cause_bd <= bus.wb_bd;
         end
         if (epc_load)    epc <= bus.wb_bd ? bus.wb_pc - 32'd4 : bus.wb_pc;
         else if (wr_epc) epc <= bus.cp0_wdata;
         if (bva_exc) badvaddr <= bus.wb_badvaddr;
      end
   end

   // Prescaled Count, Compare and the timer interrupt flag
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         count    <= '0;
         prescale <= '0;
         compare  <= 32'hFFFF_FFFF;
         cause_ti <= 1'b0;
      end else begin
         if (wr_count) begin
            count    <= bus.cp0_wdata;
            prescale <= '0;
         end else if (prescale == PRE_TOP) begin
            count    <= count + 32'd1;
            prescale <= '0;
         end else begin
            prescale <= prescale + PRE_W'(1);
         end
         if (wr_compare) compare <= bus.cp0_wdata;
         if (wr_compare)              cause_ti <= 1'b0;
         else if (count == compare)   cause_ti <= 1'b1;
      end
   end

   // TLB-facing registers
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         index_p         <= 1'b0;
         index_val       <= '0;
         random_val      <= RND_TOP;
         wired_val       <= '0;
         entryhi_vpn2    <= '0;
         entryhi_asid    <= '0;
         entrylo0        <= '0;
         entrylo1        <= '0;
         context_ptebase <= '0;
         context_badvpn2 <= '0;
      end else begin
         if (bus.tlbp) begin
            index_p <= !bus.s1_found;
            if (bus.s1_found) index_val <= bus.s1_index;
         end else if (wr_index) begin
            index_val <= bus.cp0_wdata[IDX_W-1:0];
         end
         if (wr_wired) wired_val <= bus.cp0_wdata[IDX_W-1:0];
         // Random wraps back to the top once it reaches Wired, never dipping below it
         if (wr_wired || (random_val == wired_val)) random_val <= RND_TOP;
         else                                       random_val <= random_val - IDX_W'(1);
         if (tlb_exc)         entryhi_vpn2 <= bus.wb_badvaddr[31:13];
         else if (bus.tlbr)   entryhi_vpn2 <= bus.r_vpn2;
         else if (wr_entryhi) entryhi_vpn2 <= bus.cp0_wdata[31:13];
         if (bus.tlbr)        entryhi_asid <= bus.r_asid;
         else if (wr_entryhi) entryhi_asid <= bus.cp0_wdata[7:0];
         if (bus.tlbr) begin
            entrylo0 <= {bus.r_pfn0, bus.r_c0, bus.r_d0, bus.r_v0, bus.r_g};
            entrylo1 <= {bus.r_pfn1, bus.r_c1, bus.r_d1, bus.r_v1, bus.r_g};
         end else begin
            if (wr_entrylo0) entrylo0 <= bus.cp0_wdata[25:0];
            if (wr_entrylo1) entrylo1 <= bus.cp0_wdata[25:0];
         end
         if (wr_context) context_ptebase <= bus.cp0_wdata[31:23];
         if (tlb_exc)    context_badvpn2 <= bus.wb_badvaddr[31:13];
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) int_req_q <= 1'b0;
      else         int_req_q <= status_ie && !status_exl && (|(cause_ip & status_im));
   end

   assign bus.cp0_status   = {9'd0, 1'b1, 6'd0, status_im, 6'd0, status_exl, status_ie};
   assign bus.cp0_cause    = {cause_bd, cause_ti, 14'd0, cause_ip, 1'b0, cause_excode, 2'b00};
   assign bus.cp0_epc      = epc;
   assign bus.cp0_entryhi  = {entryhi_vpn2, 5'd0, entryhi_asid};
   assign bus.cp0_entrylo0 = {6'd0, entrylo0};
   assign bus.cp0_entrylo1 = {6'd0, entrylo1};
   assign bus.cp0_index    = {index_p, {(31-IDX_W){1'b0}}, index_val};
   assign bus.int_req      = int_req_q;
   assign bus.tlb_w_index  = bus.tlbwr ? random_val : index_val;

   // MFC0 read port
   always_comb begin
      bus.cp0_rdata = '0;
      case (bus.cp0_addr)
         A_INDEX:    bus.cp0_rdata = bus.cp0_index;
         A_RANDOM:   bus.cp0_rdata = {{(32-IDX_W){1'b0}}, random_val};
         A_ENTRYLO0: bus.cp0_rdata = bus.cp0_entrylo0;
         A_ENTRYLO1: bus.cp0_rdata = bus.cp0_entrylo1;
         A_CONTEXT:  bus.cp0_rdata = {context_ptebase, context_badvpn2, 4'd0};
         A_WIRED:    bus.cp0_rdata = {{(32-IDX_W){1'b0}}, wired_val};
         A_BADVADDR: bus.cp0_rdata = badvaddr;
         A_COUNT:    bus.cp0_rdata = count;
         A_ENTRYHI:  bus.cp0_rdata = bus.cp0_entryhi;
         A_COMPARE:  bus.cp0_rdata = compare;
         A_STATUS:   bus.cp0_rdata = bus.cp0_status;
         A_CAUSE:    bus.cp0_rdata = bus.cp0_cause;
         A_EPC:      bus.cp0_rdata = epc;
         default:    bus.cp0_rdata = '0;
      endcase
   end
endmodule
